// File: rtl/axi_dw_w_packer_if.sv
// axi_dw_w_packer_if: command, narrow W and wide W bundle for the W packer
interface axi_dw_w_packer_if #(
  parameter int unsigned SlvDataWidth = 32,
  parameter int unsigned MstDataWidth = 64,
  parameter int unsigned UserWidth    = 8
);
   localparam int unsigned SlvStrbW = SlvDataWidth / 8;
   localparam int unsigned MstStrbW = MstDataWidth / 8;
   localparam int unsigned OffW     = $clog2(MstStrbW);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [OffW-1:0]         cmd_offset;
   logic [2:0]              cmd_size;
   logic [7:0]              cmd_len;
   logic                    cmd_fixed;
   logic [SlvDataWidth-1:0] slv_w_data;
   logic [SlvStrbW-1:0]     slv_w_strb;
   logic                    slv_w_last;
   logic [UserWidth-1:0]    slv_w_user;
   logic                    slv_w_valid;
   logic                    slv_w_ready;
   logic [MstDataWidth-1:0] mst_w_data;
   logic [MstStrbW-1:0]     mst_w_strb;
   logic                    mst_w_last;
   logic [UserWidth-1:0]    mst_w_user;
   logic                    mst_w_valid;
   logic                    mst_w_ready;
   logic                    err;
   modport slave (
      input  cmd_valid, cmd_offset, cmd_size, cmd_len, cmd_fixed,
      input  slv_w_data, slv_w_strb, slv_w_last, slv_w_user, slv_w_valid, mst_w_ready,
      output cmd_ready, slv_w_ready, mst_w_data, mst_w_strb, mst_w_last, mst_w_user, mst_w_valid, err
   );
   modport master (
      output cmd_valid, cmd_offset, cmd_size, cmd_len, cmd_fixed,
      output slv_w_data, slv_w_strb, slv_w_last, slv_w_user, slv_w_valid, mst_w_ready,
      input  cmd_ready, slv_w_ready, mst_w_data, mst_w_strb, mst_w_last, mst_w_user, mst_w_valid, err
   );
endinterface

// File: rtl/axi_dw_w_packer.sv
// axi_dw_w_packer: merges narrow W beats into registered wide W beats, one burst at a time.
// Optional WLAST consistency flag on err when AXI_DW_W_PACKER_LAST_CHECK_EN is defined.
module axi_dw_w_packer #(
  parameter int unsigned SlvDataWidth = 32,
  parameter int unsigned MstDataWidth = 64,
  parameter int unsigned UserWidth    = 8
) (
   input logic              clk_i,
   input logic              rst_ni,
   axi_dw_w_packer_if.slave bus
);
   localparam int unsigned SlvStrbW = SlvDataWidth / 8;
   localparam int unsigned MstStrbW = MstDataWidth / 8;
   localparam int unsigned OffW     = $clog2(MstStrbW);
   localparam int unsigned SlvOffW  = $clog2(SlvStrbW);
   typedef enum logic {IDLE, PACK} state_t;
   state_t                  state_q, state_d;
   logic [OffW-1:0]         off_q, step, nxt_off;
   logic [2:0]              size_q, size_c;
   logic [7:0]              cnt_q;
   logic                    fixed_q;
   logic [MstDataWidth-1:0] acc_data_q, mrg_data, out_data_q;
   logic [MstStrbW-1:0]     acc_strb_q, mrg_strb, out_strb_q;
   logic [UserWidth-1:0]    out_user_q;
   logic                    out_last_q, out_valid_q;
   logic                    cmd_hs, slv_hs, fin, emit;
   assign bus.cmd_ready   = state_q == IDLE;
   assign bus.slv_w_ready = state_q == PACK && (!out_valid_q || bus.mst_w_ready);
   assign bus.mst_w_data  = out_data_q;
   assign bus.mst_w_strb  = out_strb_q;
   assign bus.mst_w_last  = out_last_q;
   assign bus.mst_w_user  = out_user_q;
   assign bus.mst_w_valid = out_valid_q;
   assign cmd_hs  = bus.cmd_valid && bus.cmd_ready;
   assign slv_hs  = bus.slv_w_valid && bus.slv_w_ready;
   assign size_c  = bus.cmd_size > 3'(SlvOffW) ? 3'(SlvOffW) : bus.cmd_size;
   assign step    = OffW'(1) << size_q;
   // Align down to the beat size before stepping, so an unaligned start lands on the next natural lane.
   assign nxt_off = (off_q & ~(step - 1'b1)) + step;
   assign fin     = cnt_q == 8'd0;
   assign emit    = fixed_q || nxt_off == '0 || fin;
   always_comb begin
      mrg_data = acc_data_q;
      mrg_strb = acc_strb_q;
      for (int unsigned i = 0; i < MstStrbW; i++)
         if (i / SlvStrbW == 32'(off_q >> SlvOffW) && bus.slv_w_strb[i % SlvStrbW]) begin
            mrg_data[8*i +: 8] = bus.slv_w_data[8*(i % SlvStrbW) +: 8];
            mrg_strb[i] = 1'b1;
         end
   end
   always_comb begin
      state_d = state_q;
      if (cmd_hs) state_d = PACK;
      if (slv_hs && fin) state_d = IDLE;
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state_q <= IDLE;
      else state_q <= state_d;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         off_q       <= '0;
         size_q      <= '0;
         cnt_q       <= '0;
         fixed_q     <= 1'b0;
         acc_data_q  <= '0;
         acc_strb_q  <= '0;
         out_data_q  <= '0;
         out_strb_q  <= '0;
         out_last_q  <= 1'b0;
         out_user_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (out_valid_q && bus.mst_w_ready) out_valid_q <= 1'b0;
         if (cmd_hs) begin
            off_q      <= bus.cmd_offset;
            size_q     <= size_c;
            cnt_q      <= bus.cmd_len;
            fixed_q    <= bus.cmd_fixed;
            acc_data_q <= '0;
            acc_strb_q <= '0;
         end
         if (slv_hs) begin
            off_q <= fixed_q ? off_q : nxt_off;
            cnt_q <= cnt_q - 8'd1;
            acc_data_q <= emit ? '0 : mrg_data;
            acc_strb_q <= emit ? '0 : mrg_strb;
            if (emit) begin
               out_data_q  <= mrg_data;
               out_strb_q  <= mrg_strb;
               out_last_q  <= fin;
               out_user_q  <= bus.slv_w_user;
               out_valid_q <= 1'b1;
            end
         end
      end
`ifdef AXI_DW_W_PACKER_LAST_CHECK_EN
   logic err_q;
   assign bus.err = err_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) err_q <= 1'b0;
      else if (slv_hs && bus.slv_w_last != fin) err_q <= 1'b1;
`else
   assign bus.err = 1'b0;
`endif
endmodule
